// File: rtl/useq_if.sv
// useq_if: sequencer-side bundle of the control-store, instruction-fetch,
// flag and decoded register-bus signals for useq_ctrl.
//   master : the sequencer (drives uaddr, mem_req, bus selects, ctrl, ir,
//            halted, stack_err; receives uword, inst_in, mem_ack, flags, stall)
//   slave  : the surrounding datapath / control store / memory
interface useq_if #(
    parameter int UADDR_W = 7
) ();
    logic [UADDR_W-1:0] uaddr;
    logic [31:0]        uword;
    logic [19:0]        inst_in;
    logic               mem_req;
    logic               mem_ack;
    logic               z_flag;
    logic               n_flag;
    logic               stall;
    logic               R_read;
    logic               R_write;
    logic [5:0]         uInstA;
    logic [5:0]         uInstC;
    logic [7:0]         ctrl;
    logic [19:0]        ir;
    logic               halted;
    logic               stack_err;

    modport master (
        output uaddr, mem_req, R_read, R_write, uInstA, uInstC, ctrl, ir,
               halted, stack_err,
        input  uword, inst_in, mem_ack, z_flag, n_flag, stall
    );

    modport slave (
        input  uaddr, mem_req, R_read, R_write, uInstA, uInstC, ctrl, ir,
               halted, stack_err,
        output uword, inst_in, mem_ack, z_flag, n_flag, stall
    );
endinterface

// File: rtl/useq_ctrl.sv
// useq_ctrl: microprogram sequencer for the EV22 processor.
// Holds the micro-PC, reads microwords from an external combinational control
// store and decodes them into register-bus selects and the datapath control
// byte. Handles instruction fetch (req/ack), opcode dispatch, flag branches
// and micro-subroutine call/return.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : useq_if.master (uaddr/uword control store, inst_in/mem_req/
//            mem_ack fetch, z_flag/n_flag/stall, R_read/R_write/uInstA/
//            uInstC/ctrl decoded outputs, ir, halted, stack_err)
// Build option: define USEQ_STACK_EN for the 4-deep call stack with
// overflow/underflow halt. Without it CALL acts as JUMP and RET goes to 0.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_RST_WAIT | just out of reset, outputs quiet, moves to S_RUN next edge
// S_RUN      | one microinstruction per cycle
// S_HALT     | call-stack fault; stopped until reset
module useq_ctrl #(
    parameter int UADDR_W = 7
) (
    input  logic   clk,
    input  logic   rst_n,
    useq_if.master bus
);
    typedef enum logic [1:0] {
        S_RST_WAIT = 2'd0,
        S_RUN      = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BRZ      = 3'd2;
    localparam logic [2:0] OP_BRN      = 3'd3;
    localparam logic [2:0] OP_DISPATCH = 3'd4;
    localparam logic [2:0] OP_CALL     = 3'd5;
    localparam logic [2:0] OP_RET      = 3'd6;
    localparam logic [2:0] OP_FETCH    = 3'd7;

    state_t             state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [19:0]        ir_q, ir_d;

    logic [2:0]         op;
    logic [UADDR_W-1:0] target;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] disp_addr;
    logic               run;
    logic               halt_st;

`ifdef USEQ_STACK_EN
    logic [UADDR_W-1:0] stack_q [4];
    logic [UADDR_W-1:0] stack_d [4];
    logic [2:0]         sp_q, sp_d;
    logic [2:0]         sp_dec;
    assign sp_dec = sp_q - 3'd1;
`endif

    assign op      = bus.uword[31:29];
    assign target  = UADDR_W'(bus.uword[14:8]);
    assign upc_inc = upc_q + UADDR_W'(1);
    // Top half of the micro-address space holds the opcode entry points;
    // setting the MSB over a 6-bit opcode equals 2^(UADDR_W-1) + opcode.
    assign disp_addr = {1'b1, (UADDR_W-1)'(ir_q[19:14])};
    assign run     = (state_q == S_RUN);
    assign halt_st = (state_q == S_HALT);

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        ir_d    = ir_q;
`ifdef USEQ_STACK_EN
        stack_d = stack_q;
        sp_d    = sp_q;
`endif
        case (state_q)
            S_RST_WAIT: state_d = S_RUN;
            S_RUN: begin
                if (!bus.stall) begin
                    case (op)
                        OP_NEXT:     upc_d = upc_inc;
                        OP_JUMP:     upc_d = target;
                        OP_BRZ:      upc_d = bus.z_flag ? target : upc_inc;
                        OP_BRN:      upc_d = bus.n_flag ? target : upc_inc;
                        OP_DISPATCH: upc_d = disp_addr;
                        OP_CALL: begin
`ifdef USEQ_STACK_EN
                            if (sp_q == 3'd4) begin
                                state_d = S_HALT;
                            end else begin
                                stack_d[sp_q[1:0]] = upc_inc;
                                sp_d  = sp_q + 3'd1;
                                upc_d = target;
                            end
`else
                            upc_d = target;
`endif
                        end
                        OP_RET: begin
`ifdef USEQ_STACK_EN
                            if (sp_q == 3'd0) begin
                                state_d = S_HALT;
                            end else begin
                                upc_d = stack_q[sp_dec[1:0]];
                                sp_d  = sp_dec;
                            end
`else
                            upc_d = '0;
`endif
                        end
                        default: begin
                            // FETCH: word re-executes until the ack cycle
                            if (bus.mem_ack) begin
                                ir_d  = bus.inst_in;
                                upc_d = upc_inc;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST_WAIT;
            upc_q   <= '0;
            ir_q    <= '0;
`ifdef USEQ_STACK_EN
            sp_q    <= '0;
            for (int i = 0; i < 4; i++) stack_q[i] <= '0;
`endif
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ir_q    <= ir_d;
`ifdef USEQ_STACK_EN
            sp_q    <= sp_d;
            stack_q <= stack_d;
`endif
        end
    end

    assign bus.uaddr   = upc_q;
    assign bus.R_read  = run & bus.uword[28];
    assign bus.R_write = run & bus.uword[27];
    assign bus.uInstA  = run ? bus.uword[26:21] : 6'd0;
    assign bus.uInstC  = run ? bus.uword[20:15] : 6'd0;
    assign bus.ctrl    = run ? bus.uword[7:0] : 8'd0;
    assign bus.mem_req = run & ~bus.stall & (op == OP_FETCH);
    assign bus.ir      = halt_st ? 20'd0 : ir_q;
    assign bus.halted  = halt_st;
`ifdef USEQ_STACK_EN
    assign bus.stack_err = halt_st;
`else
    assign bus.stack_err = 1'b0;
`endif
endmodule

// File: tb/tb_useq_ctrl.sv
module tb_useq_ctrl;
    localparam int AW = 7;
`ifdef USEQ_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    useq_if #(.UADDR_W(AW)) bus ();
    useq_ctrl #(.UADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] cstore [128];
    assign bus.uword = cstore[bus.uaddr];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: 0 = waiting after reset, 1 = running, 2 = halted
    int          m_mode;
    logic [6:0]  m_upc;
    logic [19:0] m_ir;
    logic [6:0]  m_stack [$];

    function automatic logic [31:0] mk(input int op, input int t);
        logic [31:0] w;
        w = $urandom;
        w[31:29] = 3'(op);
        w[14:8]  = 7'(t);
        return w;
    endfunction

    task automatic fill_next();
        for (int a = 0; a < 128; a++) cstore[a] = mk(0, $urandom_range(127));
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_upc  = '0;
        m_ir   = '0;
        m_stack.delete();
    endtask

    function automatic logic [44:0] dut_outs();
        return {bus.R_read, bus.R_write, bus.uInstA, bus.uInstC, bus.ctrl,
                bus.mem_req, bus.ir, bus.halted, bus.stack_err};
    endfunction

    function automatic logic [44:0] exp_outs();
        logic [31:0] w;
        logic r;
        logic h;
        w = cstore[m_upc];
        r = (m_mode == 1);
        h = (m_mode == 2);
        return {r & w[28], r & w[27], r ? w[26:21] : 6'd0, r ? w[20:15] : 6'd0,
                r ? w[7:0] : 8'd0, r & ~bus.stall & (w[31:29] == 3'd7),
                h ? 20'd0 : m_ir, h, h & STACK_EN};
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        logic [31:0] w;
        logic [6:0]  t;
        logic [6:0]  inc;
        int          nmode;
        logic [6:0]  nupc;
        logic [19:0] nir;
        w = cstore[m_upc];
        t = w[14:8];
        inc = m_upc + 7'd1;
        nmode = m_mode;
        nupc = m_upc;
        nir = m_ir;
        if (m_mode == 0) begin
            nmode = 1;
        end else if (m_mode == 1 && !bus.stall) begin
            case (w[31:29])
                3'd0: nupc = inc;
                3'd1: nupc = t;
                3'd2: nupc = bus.z_flag ? t : inc;
                3'd3: nupc = bus.n_flag ? t : inc;
                3'd4: nupc = 7'(64 + int'(m_ir[19:14]));
                3'd5: begin
                    if (!STACK_EN) nupc = t;
                    else if (m_stack.size() == 4) nmode = 2;
                    else begin
                        m_stack.push_back(inc);
                        nupc = t;
                    end
                end
                3'd6: begin
                    if (!STACK_EN) nupc = 7'd0;
                    else if (m_stack.size() == 0) nmode = 2;
                    else nupc = m_stack.pop_back();
                end
                default: begin
                    if (bus.mem_ack) begin
                        nir = bus.inst_in;
                        nupc = inc;
                    end
                end
            endcase
        end
        @(posedge clk);
        m_mode = nmode;
        m_upc  = nupc;
        m_ir   = nir;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.mem_ack = 1'b0;
        bus.z_flag = 1'b0;
        bus.n_flag = 1'b0;
        bus.inst_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] want;
        fill_next();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.mem_ack = 1'b0;
        bus.z_flag = 1'b0;
        bus.n_flag = 1'b0;
        bus.inst_in = '0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.uaddr !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_uaddr got %0d want 0", bus.uaddr);
        end
        n_cmp++;
        if (dut_outs() !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_outs got %h want 0", dut_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 131; i++) begin
            bus.z_flag = 1'($urandom);
            bus.n_flag = 1'($urandom);
            want = (i == 0) ? 7'd0 : 7'((i - 1) % 128);
            #1;
            n_cmp++;
            if (bus.uaddr !== want) begin
                n_bad++;
                $display("FAIL reset_seq[%0d] uaddr got %0d want %0d", i, bus.uaddr, want);
            end
            n_cmp++;
            if (dut_outs() !== exp_outs()) begin
                n_bad++;
                $display("FAIL reset_seq[%0d] outs got %h want %h", i, dut_outs(), exp_outs());
            end
            model_step();
        end
    endtask

    task automatic test_fetch_dispatch();
        int req_cnt = 0;
        fill_next();
        cstore[5] = mk(7, $urandom_range(127));
        cstore[6] = mk(4, $urandom_range(127));
        do_reset();
        for (int i = 0; i <= 11; i++) begin
            bus.mem_ack = (i == 9);
            bus.inst_in = (i == 9) ? 20'hA1234 : 20'($urandom);
            #1;
            req_cnt += int'(bus.mem_req);
            n_cmp++;
            if (bus.uaddr !== m_upc) begin
                n_bad++;
                $display("FAIL fetch[%0d] uaddr got %0d want %0d", i, bus.uaddr, m_upc);
            end
            n_cmp++;
            if (dut_outs() !== exp_outs()) begin
                n_bad++;
                $display("FAIL fetch[%0d] outs got %h want %h", i, dut_outs(), exp_outs());
            end
            if (i == 11) begin
                n_cmp++;
                if (bus.uaddr !== 7'd104) begin
                    n_bad++;
                    $display("FAIL dispatch_target got %0d want 104", bus.uaddr);
                end
            end
            model_step();
        end
        bus.mem_ack = 1'b0;
        n_cmp++;
        if (req_cnt != 4) begin
            n_bad++;
            $display("FAIL fetch_req_cycles got %0d want 4", req_cnt);
        end
        n_cmp++;
        if (bus.ir !== 20'hA1234) begin
            n_bad++;
            $display("FAIL fetch_ir got %h want a1234", bus.ir);
        end
    endtask

    task automatic test_branch();
        fill_next();
        cstore[9]  = mk(2, 20);
        cstore[10] = mk(1, 9);
        do_reset();
        for (int i = 0; i <= 13; i++) begin
            bus.z_flag = (i == 12) ? 1'b1 : (i == 10) ? 1'b0 : 1'($urandom);
            bus.n_flag = 1'($urandom);
            #1;
            n_cmp++;
            if (bus.uaddr !== m_upc) begin
                n_bad++;
                $display("FAIL branch[%0d] uaddr got %0d want %0d", i, bus.uaddr, m_upc);
            end
            n_cmp++;
            if (dut_outs() !== exp_outs()) begin
                n_bad++;
                $display("FAIL branch[%0d] outs got %h want %h", i, dut_outs(), exp_outs());
            end
            if (i == 11 || i == 13) begin
                n_cmp++;
                if (bus.uaddr !== ((i == 11) ? 7'd10 : 7'd20)) begin
                    n_bad++;
                    $display("FAIL brz_step%0d got %0d want %0d", i, bus.uaddr, (i == 11) ? 10 : 20);
                end
            end
            model_step();
        end
    endtask

    task automatic test_stack();
        logic [6:0] seq_a [9];
`ifdef USEQ_STACK_EN
        seq_a = '{7'd0, 7'd10, 7'd20, 7'd30, 7'd40, 7'd31, 7'd21, 7'd11, 7'd1};
`else
        seq_a = '{7'd0, 7'd10, 7'd20, 7'd30, 7'd40, 7'd0, 7'd10, 7'd20, 7'd30};
`endif
        for (int run = 0; run < 2; run++) begin
            fill_next();
            cstore[0]  = mk(5, 10);
            cstore[10] = mk(5, 20);
            cstore[20] = mk(5, 30);
            cstore[30] = mk(5, 40);
            cstore[40] = (run == 0) ? mk(6, 0) : mk(5, 50);
            cstore[31] = mk(6, 0);
            cstore[21] = mk(6, 0);
            cstore[11] = mk(6, 0);
            cstore[1]  = mk(6, 0);
            do_reset();
            for (int i = 0; i <= 11; i++) begin
                #1;
                n_cmp++;
                if (bus.uaddr !== m_upc) begin
                    n_bad++;
                    $display("FAIL stack%0d[%0d] uaddr got %0d want %0d", run, i, bus.uaddr, m_upc);
                end
                n_cmp++;
                if (dut_outs() !== exp_outs()) begin
                    n_bad++;
                    $display("FAIL stack%0d[%0d] outs got %h want %h", run, i, dut_outs(), exp_outs());
                end
                if (run == 0 && i >= 1 && i <= 9) begin
                    n_cmp++;
                    if (bus.uaddr !== seq_a[i-1]) begin
                        n_bad++;
                        $display("FAIL call_ret_order[%0d] got %0d want %0d", i, bus.uaddr, seq_a[i-1]);
                    end
                end
                if ((run == 0 && i == 10) || (run == 1 && i == 6)) begin
                    n_cmp++;
                    if ({bus.halted, bus.stack_err} !== (STACK_EN ? 2'b11 : 2'b00)) begin
                        n_bad++;
                        $display("FAIL stack_fault%0d halted/err got %b want %b", run,
                                 {bus.halted, bus.stack_err}, STACK_EN ? 2'b11 : 2'b00);
                    end
                end
                if (run == 1 && i == 6) begin
                    n_cmp++;
                    if (bus.uaddr !== (STACK_EN ? 7'd40 : 7'd50)) begin
                        n_bad++;
                        $display("FAIL overflow_uaddr got %0d want %0d", bus.uaddr, STACK_EN ? 40 : 50);
                    end
                end
                model_step();
            end
        end
    endtask

    task automatic test_stall();
        fill_next();
        cstore[5] = mk(7, $urandom_range(127));
        do_reset();
        for (int i = 0; i <= 9; i++) begin
            bus.stall = (i == 6 || i == 7);
            bus.mem_ack = (i >= 6 && i <= 8);
            bus.inst_in = 20'h5A5A5;
            #1;
            n_cmp++;
            if (bus.uaddr !== m_upc) begin
                n_bad++;
                $display("FAIL stall[%0d] uaddr got %0d want %0d", i, bus.uaddr, m_upc);
            end
            n_cmp++;
            if (dut_outs() !== exp_outs()) begin
                n_bad++;
                $display("FAIL stall[%0d] outs got %h want %h", i, dut_outs(), exp_outs());
            end
            if (i == 8) begin
                n_cmp++;
                if ({bus.uaddr, bus.ir, bus.mem_req} !== {7'd5, 20'd0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL stall_hold uaddr/ir/req got %0d/%h/%b want 5/00000/1",
                             bus.uaddr, bus.ir, bus.mem_req);
                end
            end
            if (i == 9) begin
                n_cmp++;
                if ({bus.uaddr, bus.ir} !== {7'd6, 20'h5A5A5}) begin
                    n_bad++;
                    $display("FAIL stall_accept uaddr/ir got %0d/%h want 6/5a5a5", bus.uaddr, bus.ir);
                end
            end
            model_step();
        end
        bus.stall = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        fill_next();
        cstore[0] = mk(7, 0);
        cstore[5] = mk(7, 0);
        cstore[6] = mk(1, 5);
        do_reset();
        for (int i = 0; i <= 9; i++) begin
            bus.mem_ack = (i <= 1 || i == 6);
            bus.inst_in = (i == 6) ? 20'hC3C3C : 20'($urandom);
            #1;
            n_cmp++;
            if (bus.uaddr !== m_upc) begin
                n_bad++;
                $display("FAIL midrst[%0d] uaddr got %0d want %0d", i, bus.uaddr, m_upc);
            end
            n_cmp++;
            if (dut_outs() !== exp_outs()) begin
                n_bad++;
                $display("FAIL midrst[%0d] outs got %h want %h", i, dut_outs(), exp_outs());
            end
            model_step();
        end
        bus.mem_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({bus.uaddr, bus.ir, bus.mem_req} !== 28'd0) begin
            n_bad++;
            $display("FAIL async_clear uaddr/ir/req got %0d/%h/%b want 0/00000/0",
                     bus.uaddr, bus.ir, bus.mem_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = 1'b1;
            bus.inst_in = 20'($urandom);
            #1;
            n_cmp++;
            if (bus.uaddr !== m_upc) begin
                n_bad++;
                $display("FAIL postrst[%0d] uaddr got %0d want %0d", i, bus.uaddr, m_upc);
            end
            n_cmp++;
            if (dut_outs() !== exp_outs()) begin
                n_bad++;
                $display("FAIL postrst[%0d] outs got %h want %h", i, dut_outs(), exp_outs());
            end
            model_step();
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int a = 0; a < 128; a++) cstore[a] = mk($urandom_range(7), $urandom_range(127));
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ((m_mode == 2 && $urandom_range(3) == 0) || $urandom_range(199) == 0) begin
                for (int a = 0; a < 128; a++) cstore[a] = mk($urandom_range(7), $urandom_range(127));
                do_reset();
            end
            bus.stall   = ($urandom_range(4) == 0);
            bus.mem_ack = ($urandom_range(9) < 4);
            bus.z_flag  = 1'($urandom);
            bus.n_flag  = 1'($urandom);
            bus.inst_in = 20'($urandom);
            #1;
            n_cmp++;
            if (bus.uaddr !== m_upc) begin
                n_bad++;
                $display("FAIL random[%0d] uaddr got %0d want %0d", i, bus.uaddr, m_upc);
            end
            n_cmp++;
            if (dut_outs() !== exp_outs()) begin
                n_bad++;
                $display("FAIL random[%0d] outs got %h want %h", i, dut_outs(), exp_outs());
            end
            model_step();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_dispatch();
        test_branch();
        test_stack();
        test_stall();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
